// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : can_tx_scheduler
// Brief   : Two-channel CAN transmit arbiter/sequencer with bounded retry.
//           Define CAN_TX_STRICT_PRIORITY_EN for fixed ch1 priority.
// Rev     : 1.0
// ============================================================================
module can_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] can_tx_data,
  output logic              can_write,
  input  logic              can_tx_done,
  input  logic              can_tx_err,
  output logic              busy,
  output logic              grant_id,
  output logic              drop_err
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_tmr_max  = '1;
  localparam logic [RTY_W-1:0] c_rty_max  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q;
  logic              rr_ptr_q;
  logic [RTY_W-1:0]  retry_q;
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] frame_q;
  logic              grant_q;
  logic              write_q;
  logic              drop_q;

  logic              w_win;
  logic              w_idle;
  logic              w_xfer;
  logic [DATA_W-1:0] w_frame;

  always_comb begin
    w_win = 1'b0;
`ifdef CAN_TX_STRICT_PRIORITY_EN
    w_win = req1_valid;
`else
    if (req0_valid && req1_valid) begin
      w_win = rr_ptr_q;
    end else begin
      w_win = req1_valid;
    end
`endif
  end

  // Gated by n_rst so no handshake can be signalled while reset is held.
  assign w_idle     = n_rst && (state_q == S_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_win;
  assign req1_ready = w_idle && req1_valid && w_win;
  assign w_xfer     = req0_ready || req1_ready;
  assign w_frame    = w_win ? req1_data : req0_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      retry_q  <= '0;
      timer_q  <= '0;
      frame_q  <= '0;
      grant_q  <= 1'b0;
      write_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      drop_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_xfer) begin
            frame_q <= w_frame;
            grant_q <= w_win;
            retry_q <= '0;
            write_q <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (timer_q != c_tmr_max) begin
            timer_q <= timer_q + 1'b1;
          end
          // Completion takes precedence over a coincident error.
          if (can_tx_done) begin
            state_q <= S_IDLE;
`ifdef CAN_TX_STRICT_PRIORITY_EN
            rr_ptr_q <= 1'b0;
`else
            rr_ptr_q <= ~grant_q;
`endif
          end else if (can_tx_err || (timer_q == c_tmr_last)) begin
            if (retry_q < c_rty_max) begin
              retry_q <= retry_q + 1'b1;
              write_q <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              drop_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign can_tx_data = frame_q;
  assign can_write   = write_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign drop_err    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_can_tx_scheduler
// Brief   : Self-checking bench for can_tx_scheduler against a frame-level model.
// Rev     : 1.0
// ============================================================================
module tb_can_tx_scheduler;

  localparam int TMO = 16;
  localparam int MR  = 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic [31:0] can_tx_data;
  logic        can_write;
  logic        can_tx_done = 1'b0;
  logic        can_tx_err = 1'b0;
  logic        busy;
  logic        grant_id;
  logic        drop_err;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;
  // Responder plan per attempt: 0=done, 1=err, 2=done+err, 3=silent; delay 1..TMO
  int plan_out[MR+1];
  int plan_dly[MR+1];

  can_tx_scheduler #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .can_tx_data(can_tx_data), .can_write(can_write),
    .can_tx_done(can_tx_done), .can_tx_err(can_tx_err),
    .busy(busy), .grant_id(grant_id), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_winner(input logic v0, input logic v1);
`ifdef CAN_TX_STRICT_PRIORITY_EN
    return v1 ? 1 : 0;
`else
    if (v0 && v1) return rr_m;
    return v1 ? 1 : 0;
`endif
  endfunction

  // Starts and ends at a sample point with the DUT idle.
  task automatic run_frame(input string tag, input logic v0, input logic v1,
                           input logic [31:0] d0, input logic [31:0] d1);
    int          win;
    int          n_att;
    int          nw;
    logic        exp_drop;
    logic [31:0] exp_d;
    win   = exp_winner(v0, v1);
    exp_d = (win == 1) ? d1 : d0;
    n_att = MR + 1;
    exp_drop = 1'b1;
    for (int k = MR; k >= 0; k--) begin
      if (plan_out[k] == 0 || plan_out[k] == 2) begin
        n_att = k + 1;
        exp_drop = 1'b0;
      end
    end
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    can_tx_done = 1'($urandom_range(0, 1));
    can_tx_err  = 1'($urandom_range(0, 1));
    #1;
    total++;
    if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
      bad++;
      $display("FAIL %s accept_ready: got r0=%b r1=%b want winner ch%0d", tag, req0_ready, req1_ready, win);
    end
    tick();
    for (int a = 0; a < n_att; a++) begin
      can_tx_done = 1'($urandom_range(0, 1));
      can_tx_err  = 1'($urandom_range(0, 1));
      total++;
      if (can_write !== 1'b1 || can_tx_data !== exp_d || grant_id !== win[0] || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s strobe%0d: got wr=%b data=%h gid=%b busy=%b want wr=1 data=%h gid=%0d busy=1",
                 tag, a, can_write, can_tx_data, grant_id, busy, exp_d, win);
      end
      tick();
      nw = (plan_out[a] == 3) ? TMO : plan_dly[a];
      for (int j = 0; j < nw; j++) begin
        can_tx_done = (j == nw - 1) && (plan_out[a] == 0 || plan_out[a] == 2);
        can_tx_err  = (j == nw - 1) && (plan_out[a] == 1 || plan_out[a] == 2);
        total++;
        if (can_write !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0
            || drop_err !== 1'b0) begin
          bad++;
          $display("FAIL %s wait%0d.%0d: got wr=%b busy=%b r0=%b r1=%b drop=%b want wr=0 busy=1 r0=0 r1=0 drop=0",
                   tag, a, j, can_write, busy, req0_ready, req1_ready, drop_err);
        end
        tick();
      end
      can_tx_done = 1'b0;
      can_tx_err  = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || can_write !== 1'b0 || drop_err !== exp_drop || grant_id !== win[0]
        || can_tx_data !== exp_d) begin
      bad++;
      $display("FAIL %s end: got busy=%b wr=%b drop=%b gid=%b data=%h want busy=0 wr=0 drop=%b gid=%0d data=%h",
               tag, busy, can_write, drop_err, grant_id, can_tx_data, exp_drop, win, exp_d);
    end
    if (!exp_drop) rr_m = 1 - win;
    if (exp_drop) begin
      tick();
      total++;
      if (drop_err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s drop_pulse_len: got drop=%b busy=%b want drop=0 busy=0", tag, drop_err, busy);
      end
    end
  endtask

  task automatic set_plan(input int o0, input int t0, input int o1, input int t1,
                          input int o2, input int t2, input int o3, input int t3);
    plan_out[0] = o0; plan_dly[0] = t0;
    plan_out[1] = o1; plan_dly[1] = t1;
    plan_out[2] = o2; plan_dly[2] = t2;
    plan_out[3] = o3; plan_dly[3] = t3;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #23;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || can_tx_data !== 32'h0 || can_write !== 1'b0
        || busy !== 1'b0 || grant_id !== 1'b0 || drop_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got r0=%b r1=%b data=%h wr=%b busy=%b gid=%b drop=%b want all 0",
               req0_ready, req1_ready, can_tx_data, can_write, busy, grant_id, drop_err);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_rst = 1'b1;
    rr_m = 0;
    tick();
  endtask

  task automatic test_single();
    set_plan(0, 5, 0, 1, 0, 1, 0, 1);
    run_frame("single", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      set_plan(0, 1 + i, 0, 1, 0, 1, 0, 1);
      run_frame("contention", 1'b1, 1'b1, 32'h11111111, 32'h22222222);
    end
  endtask

  task automatic test_retry();
    set_plan(1, 2, 1, 3, 0, 1, 0, 1);
    run_frame("retry", 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    set_plan(0, 1, 0, 1, 0, 1, 0, 1);
    run_frame("retry_rr", 1'b1, 1'b1, 32'h0BADF00D, 32'hFEEDFACE);
  endtask

  task automatic test_timeout_drop();
    set_plan(3, 1, 3, 1, 3, 1, 3, 1);
    run_frame("timeout_drop", 1'b1, 1'b0, 32'hC0FFEE00, 32'h0);
    set_plan(1, 1, 3, 1, 1, 16, 3, 1);
    run_frame("mixed_drop", 1'b0, 1'b1, 32'h0, 32'h5A5A0001);
    set_plan(0, 2, 0, 1, 0, 1, 0, 1);
    run_frame("drop_rr", 1'b1, 1'b1, 32'h01020304, 32'h05060708);
  endtask

  task automatic test_done_err_same();
    set_plan(2, 2, 1, 1, 1, 1, 1, 1);
    run_frame("done_err_same", 1'b1, 1'b0, 32'h13572468, 32'h0);
  endtask

  task automatic test_random();
    logic v0, v1;
    int   r;
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(1, 3));
      v0 = r[0];
      v1 = r[1];
      for (int k = 0; k <= MR; k++) begin
        r = int'($urandom_range(0, 9));
        plan_out[k] = (r < 4) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
        plan_dly[k] = int'($urandom_range(1, TMO));
      end
      run_frame("random", v0, v1, $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_data = 32'h77778888;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || can_tx_data !== 32'h0 || can_write !== 1'b0
        || busy !== 1'b0 || grant_id !== 1'b0 || drop_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got r0=%b r1=%b data=%h wr=%b busy=%b gid=%b drop=%b want all 0",
               req0_ready, req1_ready, can_tx_data, can_write, busy, grant_id, drop_err);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || can_write !== 1'b0 || req0_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got busy=%b wr=%b r0=%b want 0 0 0", busy, can_write, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_rst = 1'b1;
    rr_m = 0;
    tick();
    set_plan(0, 3, 0, 1, 0, 1, 0, 1);
    run_frame("post_reset", 1'b1, 1'b0, 32'h12345678, 32'h0);
    set_plan(0, 1, 0, 1, 0, 1, 0, 1);
    run_frame("post_reset_rr", 1'b1, 1'b1, 32'hAAAA0000, 32'hBBBB1111);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_retry();
    test_timeout_drop();
    test_done_err_same();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Sits between the Control_Unit and can_register.
- Arbitrates two transmit requesters for the single CAN transmit path:
  - ch0: command-FIFO drain path.
  - ch1: control-unit status/heartbeat frames.
- Sequences each frame into can_register with a one-cycle write strobe, waits for completion, and retries on error/timeout up to a bounded count.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for can_tx_done or can_tx_err before declaring a timeout.
- MAX_RETRY, 3: retransmissions allowed after the first attempt before the frame is dropped.
- DATA_W, 32: frame word width.

Ports:
- clk  input  1  system clock (HCLK)
- n_rst  input  1  asynchronous active-low reset
- req0_valid  input  1  ch0 frame available
- req0_data  input  DATA_W  ch0 frame word
- req0_ready  output  1  ch0 frame accepted this cycle
- req1_valid  input  1  ch1 frame available
- req1_data  input  DATA_W  ch1 frame word
- req1_ready  output  1  ch1 frame accepted this cycle
- can_tx_data  output  DATA_W  frame presented to can_register command port
- can_write  output  1  one-cycle write strobe to can_register
- can_tx_done  input  1  frame transmitted successfully (1-cycle pulse)
- can_tx_err  input  1  frame failed (bit/ack error, lost arbitration; 1-cycle pulse)
- busy  output  1  frame in flight (any state except IDLE)
- grant_id  output  1  channel owning the current/last frame
- drop_err  output  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Clock/reset: one clock clk; reset n_rst is asynchronous, active-low.
- Reset values:
  - All outputs 0: req*_ready, can_tx_data, can_write, busy, grant_id, drop_err.
  - State IDLE, rr_ptr=0, retry_cnt=0, timer=0.
- Handshake: a transfer occurs on req*_valid & req*_ready. req*_ready is combinational, asserted only in IDLE and only for the granted channel; at most one ready high per cycle.
- Arbitration in IDLE:
  - Only one valid: that channel wins.
  - Both valid: the channel equal to rr_ptr wins.
  - On a successful transmission, rr_ptr <= ~grant_id. rr_ptr is unchanged on drop.
- States:
  - IDLE: on a transfer, latch data into frame_reg, grant_id <= winner, retry_cnt <= 0, go LOAD.
  - LOAD:
    - can_write=1 for exactly one cycle; can_tx_data=frame_reg, held stable until the next frame is latched.
    - timer <= 0; go WAIT.
  - WAIT: timer increments each cycle.
    - can_tx_done: go IDLE.
    - Else can_tx_err, or timer==TIMEOUT_CYCLES-1:
      - If retry_cnt<MAX_RETRY: retry_cnt++, go LOAD.
      - Else: drop_err=1 for one cycle, go IDLE.
- Latency: valid seen in IDLE at cycle N; ready at N; can_write at N+1; earliest next acceptance is the cycle after done.
- can_tx_done and can_tx_err in the same cycle: done wins.
- done/err outside WAIT: ignored.
- Timer: width clog2(TIMEOUT_CYCLES); saturates, never wraps. Cleared on every LOAD.
- retry_cnt: width clog2(MAX_RETRY+1). MAX_RETRY=0 means no retry.
- Reset mid-frame: in-flight frame is discarded and can_write deasserts immediately. Requesters must re-present data; no handshake completes during reset.

Optional Feature:
- Macro: CAN_TX_STRICT_PRIORITY_EN
- Defined: ch1 always wins when both channels are valid; rr_ptr is unused and held at 0.
- Undefined: round-robin as above.

Test Plan:
- Single request: req0_valid=1, data=0xDEADBEEF; done 5 cycles after can_write → req0_ready 1 cycle, can_write at N+1 with can_tx_data=0xDEADBEEF, busy 1→0, grant_id=0, no drop_err.
- Contention: both valid continuously (data 0x11111111 / 0x22222222), done after each strobe → grants alternate 0,1,0,1; with CAN_TX_STRICT_PRIORITY_EN, grants are 1,1,1,…
- Retry: req1 frame 0xA5A5A5A5, can_tx_err after each of the first 2 strobes, then done → 3 can_write pulses with identical data, no drop_err, rr_ptr flips to 0.
- Timeout drop: TIMEOUT_CYCLES=16, MAX_RETRY=3, no done/err → 4 strobes spaced 17 cycles apart (LOAD + 16 WAIT), then drop_err pulse, IDLE, rr_ptr unchanged.
- Simultaneous done and err in WAIT → treated as success: no further strobe, IDLE next cycle.
- n_rst asserted 2 cycles into WAIT → all outputs 0 asynchronously; after release, a fresh req0 at 0x12345678 is accepted with grant_id=0.
